// File: rtl/usb_tx_encoder_if.sv
// Byte stream in, USB full-speed line state out, plus packet status strobes.
// Latency: pure signal bundle, no logic.
// Backpressure: tx_ready from the encoder gates tx_valid transfers.
interface usb_tx_encoder_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  // Packet source side (drives bytes, watches the line and status)
  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
  );

  // Encoder side
  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first bits, bit stuffing, NRZI, EOP.
// Latency: first SYNC bit on the line the cycle after the accepting edge.
// Backpressure: one-byte holding register; tx_ready low while full, after the last byte, and during EOP.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic             clk,
  input logic             n_rst,
  usb_tx_encoder_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state, state_nxt, ret_state, pos;
  logic [TW-1:0] timer;
  logic          tick;
  logic [7:0]    hold_data, sh;
  logic          hold_full, hold_last, sh_last, last_seen, level;
  logic [2:0]    bit_idx, idx_nxt, ones;
  logic          ready, xfer;
  logic          start_bit, new_bit, load_sh, sh_step, err, done;
  logic          done_q, err_q;

  assign tick  = (timer == T_LAST);
  assign ready = !hold_full && !last_seen && (state != EOP_SE0) && (state != EOP_J);
  assign xfer  = bus.tx_valid && ready;

  assign bus.tx_ready = ready;
  assign bus.d_plus   = (state == EOP_SE0) ? 1'b0 : level;
  assign bus.d_minus  = (state == EOP_SE0) ? 1'b0 : ~level;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_error = err_q;

  // Next state and per-bit control; a stuff bit resumes the interrupted SYNC/DATA position
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    start_bit = 1'b0;
    new_bit   = 1'b0;
    load_sh   = 1'b0;
    sh_step   = 1'b0;
    err       = 1'b0;
    done      = 1'b0;
    pos       = (state == STUFF) ? ret_state : state;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SYNC;
          idx_nxt   = 3'd0;
          start_bit = 1'b1;
          new_bit   = 1'b0;
        end
      end
      SYNC, DATA, STUFF: begin
        if (tick) begin
          if (state != STUFF && ones == 3'd6) begin
            state_nxt = STUFF;
            start_bit = 1'b1;
            new_bit   = 1'b0;
          end else if (pos == SYNC) begin
            if (bit_idx == 3'd7) begin
              load_sh   = 1'b1;
              state_nxt = DATA;
              idx_nxt   = 3'd0;
              start_bit = 1'b1;
              new_bit   = hold_data[0];
            end else begin
              state_nxt = SYNC;
              idx_nxt   = bit_idx + 3'd1;
              start_bit = 1'b1;
              new_bit   = (bit_idx == 3'd6);
            end
          end else if (bit_idx != 3'd7) begin
            state_nxt = DATA;
            idx_nxt   = bit_idx + 3'd1;
            sh_step   = 1'b1;
            start_bit = 1'b1;
            new_bit   = sh[1];
          end else if (sh_last) begin
            state_nxt = EOP_SE0;
            idx_nxt   = 3'd0;
          end else if (hold_full) begin
            load_sh   = 1'b1;
            state_nxt = DATA;
            idx_nxt   = 3'd0;
            start_bit = 1'b1;
            new_bit   = hold_data[0];
          end else begin
            err       = 1'b1;
            state_nxt = EOP_SE0;
            idx_nxt   = 3'd0;
          end
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (bit_idx == 3'd1) begin
            state_nxt = EOP_J;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (tick) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timing, NRZI level, stuffing counter and byte registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
      timer     <= '0;
      bit_idx   <= 3'd0;
      ones      <= 3'd0;
      level     <= 1'b1;
      sh        <= 8'd0;
      sh_last   <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= 8'd0;
      hold_last <= 1'b0;
      last_seen <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
      done_q  <= done;
      err_q   <= err;
      if (state == IDLE || tick) timer <= '0;
      else                       timer <= timer + TW'(1);
      if (state_nxt == STUFF && state != STUFF) ret_state <= state;
      if (start_bit) begin
        ones <= new_bit ? ones + 3'd1 : 3'd0;
        if (!new_bit) level <= ~level;
      end
      if (state == EOP_SE0) level <= 1'b1;
      if (load_sh) begin
        sh        <= hold_data;
        sh_last   <= hold_last;
        hold_full <= 1'b0;
      end else if (sh_step) begin
        sh <= {1'b0, sh[7:1]};
      end
      if (xfer) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
        hold_last <= bus.tx_last;
        if (bus.tx_last) last_seen <= 1'b1;
      end
      if (done) last_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: decodes the line back into bytes against a scoreboard.
// Latency: checks packet length, SYNC placement and EOP timing at CLKS_PER_BIT = 8.
// Backpressure: holds tx_valid high across packets to check single transfers per byte.
module tb_usb_tx_encoder;
  localparam int CPB = 8;

  logic clk;
  logic n_rst;
  usb_tx_encoder_if bus ();

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  pkt[$];
  logic [7:0]  exp_q[$];
  logic [1:0]  sym_q[$];
  logic [63:0] obs_line;
  int          obs_errs;
  int          obs_xfers;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Pack a line-state string (K, J, S=SE0) two bits per symbol, {d_plus, d_minus}
  function automatic logic [63:0] pack_line(input string s);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "K")      r = {r[61:0], 2'b01};
      else if (s[i] == "J") r = {r[61:0], 2'b10};
      else                  r = {r[61:0], 2'b00};
    end
    return r;
  endfunction

  // Reference count of stuffed bits for the current packet (SYNC's final 1 counts)
  function automatic int stuff_count();
    int o = 1;
    int s = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        if (pkt[i][b]) o++;
        else           o = 0;
        if (o == 6) begin
          s++;
          o = 0;
        end
      end
    end
    return s;
  endfunction

  task automatic drive_bytes(input bit underrun);
    int i = 0;
    int guard = 0;
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = pkt[0];
    bus.tx_last  = !underrun && (pkt.size() == 1);
    while (i < pkt.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (bus.tx_ready) begin
        exp_q.push_back(pkt[i]);
        i++;
        @(posedge clk); #1;
        if (i < pkt.size()) begin
          bus.tx_data = pkt[i];
          bus.tx_last = !underrun && (i == pkt.size() - 1);
        end
      end
    end
    if (underrun) bus.tx_valid = 1'b0;
    guard = 0;
    while (bus.tx_valid && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (!bus.d_plus && !bus.d_minus) bus.tx_valid = 1'b0;
    end
  endtask

  task automatic watch_line();
    int wait_n = 0;
    int busy_n = 0;
    int ones = 0;
    int nbits = 0;
    int s_obs = 0;
    int s_bad = 0;
    int n;
    logic [1:0] prev = 2'b10;
    logic       b;
    logic [7:0] cur = 8'd0;
    logic [7:0] byte_q[$];
    sym_q.delete();
    obs_line = 64'd0;
    obs_errs = 0;
    obs_xfers = 0;
    do begin
      @(negedge clk);
      wait_n++;
      if (bus.tx_valid && bus.tx_ready) obs_xfers++;
    end while (!bus.tx_busy && wait_n < 200);
    if (!bus.tx_busy) begin
      check("busy_start", 64'(bus.tx_busy), 64'd1);
      return;
    end
    while (bus.tx_busy && busy_n < 3000) begin
      if (bus.tx_error) obs_errs++;
      if (busy_n % CPB == CPB / 2) sym_q.push_back({bus.d_plus, bus.d_minus});
      busy_n++;
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) obs_xfers++;
    end
    check("done_pulse", 64'(bus.tx_done), 64'd1);
    check("busy_len", 64'(busy_n), 64'((8 + 8 * pkt.size() + stuff_count() + 3) * CPB));
    for (int k = 0; k < sym_q.size(); k++) obs_line = {obs_line[61:0], sym_q[k]};
    // NRZI decode and destuff up to the first SE0
    for (int k = 0; k < sym_q.size(); k++) begin
      if (sym_q[k] == 2'b00) break;
      b = (sym_q[k] == prev);
      prev = sym_q[k];
      if (ones == 6) begin
        ones = 0;
        s_obs++;
        if (b) s_bad++;
      end else begin
        ones = b ? ones + 1 : 0;
        cur = {b, cur[7:1]};
        nbits++;
        if (nbits % 8 == 0) byte_q.push_back(cur);
      end
    end
    check("bit_count", 64'(nbits), 64'(8 * (pkt.size() + 1)));
    check("stuff_zero", 64'(s_bad), 64'd0);
    check("stuff_count", 64'(s_obs), 64'(stuff_count()));
    if (byte_q.size() > 0) check("sync_byte", 64'(byte_q[0]), 64'h80);
    for (int k = 1; k < byte_q.size(); k++) begin
      if (exp_q.size() == 0) check("extra_byte", 64'(byte_q[k]), 64'h100);
      else                   check("data_byte", 64'(byte_q[k]), 64'(exp_q.pop_front()));
    end
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    n = sym_q.size();
    if (n >= 3) check("eop_tail", 64'({sym_q[n-3], sym_q[n-2], sym_q[n-1]}), 64'b000010);
    else        check("eop_tail", 64'(n), 64'd3);
  endtask

  task automatic send_packet(input bit underrun);
    exp_q.delete();
    fork
      drive_bytes(underrun);
      watch_line();
    join
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'd0;
    bus.tx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lines", 64'({bus.d_plus, bus.d_minus}), 64'b10);
    check("rst_ready", 64'(bus.tx_ready), 64'd1);
    check("rst_busy", 64'({bus.tx_busy, bus.tx_done, bus.tx_error}), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_lines", 64'({bus.d_plus, bus.d_minus}), 64'b10);
    check("post_rst_ready", 64'({bus.tx_ready, bus.tx_busy}), 64'b10);

    pkt = '{8'h00};
    send_packet(1'b0);
    check("line_00", obs_line, pack_line("KJKJKJKKJKJKJKJKSSJ"));
    check("err_00", 64'(obs_errs), 64'd0);
    check("xfer_00", 64'(obs_xfers), 64'd1);

    pkt = '{8'hFF};
    send_packet(1'b0);
    check("line_ff", obs_line, pack_line("KJKJKJKKKKKKKJJJJSSJ"));
    check("err_ff", 64'(obs_errs), 64'd0);

    pkt = '{8'hA5, 8'h3C, 8'h0F};
    send_packet(1'b0);
    check("xfer_multi", 64'(obs_xfers), 64'd3);
    check("err_multi", 64'(obs_errs), 64'd0);

    pkt = '{8'h7E};
    send_packet(1'b1);
    check("underrun_err", 64'(obs_errs), 64'd1);

    // Reset in the middle of the 0xFF data byte, while the line sits at K
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    bus.tx_last  = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    check("pre_rst_k", 64'({bus.d_plus, bus.d_minus}), 64'b01);
    n_rst = 1'b0;
    #1;
    check("mid_rst_j", 64'({bus.d_plus, bus.d_minus}), 64'b10);
    check("mid_rst_st", 64'({bus.tx_busy, bus.tx_ready}), 64'b01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    pkt = '{8'h00};
    send_packet(1'b0);
    check("line_after_rst", obs_line, pack_line("KJKJKJKKJKJKJKJKSSJ"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
